cm0_dap_cdc_xfer_ctrl: RTL and testbench

CM0_DAP_CDC_XFER_CTRL -- requirements
Module: cm0_dap_cdc_xfer_ctrl

---
 rtl/cm0_dap_cdc_xfer_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cm0_dap_cdc_xfer_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cm0_dap_cdc_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// cm0_dap_cdc_xfer_ctrl
//
// Source-side controller for a 4-phase request/acknowledge word transfer
// into another clock domain through an AND-mask CDC. The word is captured
// into a holding register. The mask is opened one cycle after the data has
// settled. The request is raised one cycle after the mask opens. Both the
// mask and the request drop together once the synchronised acknowledge is
// seen. An optional cycle limit aborts a request that is never acknowledged
// and sets a sticky error.
//
// Parameters
//   PRESENT   : 0 removes the block; every output is tied to 0.
//   TIMEOUT   : cycle limit for the acknowledge wait (16 bit), 0 = no limit.
//
// Ports
//   SWCLKTCK  in   the only clock; all flops are rising-edge
//   DPRESETn  in   synchronous active-low reset
//   REQ_VALID in   source has a word to transfer
//   REQ_DATA  in   [31:0] word to transfer
//   REQ_READY out  word is accepted this cycle when REQ_VALID is also 1
//   CDC_DATA  out  [31:0] held word, feeds DATAIN of the CDC AND mask
//   CDC_MASKn out  mask enable, feeds MASKn of the CDC AND mask
//   CDC_REQ   out  4-phase request to the destination domain
//   CDC_ACK   in   4-phase acknowledge, asynchronous to SWCLKTCK
//   DONE      out  one-cycle pulse when the acknowledge is received
//   ERR       out  sticky timeout flag
//   ERR_CLR   in   clears ERR (a simultaneous new timeout wins)
// ---------------------------------------------------------------------------
module cm0_dap_cdc_xfer_ctrl #(
  parameter int unsigned PRESENT = 1,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        SWCLKTCK,
  input  logic        DPRESETn,
  input  logic        REQ_VALID,
  input  logic [31:0] REQ_DATA,
  output logic        REQ_READY,
  output logic [31:0] CDC_DATA,
  output logic        CDC_MASKn,
  output logic        CDC_REQ,
  input  logic        CDC_ACK,
  output logic        DONE,
  output logic        ERR,
  input  logic        ERR_CLR
);

  typedef enum logic [2:0] {
    st_idle    = 3'd0,
    st_load    = 3'd1,
    st_open    = 3'd2,
    st_req     = 3'd3,
    st_release = 3'd4
  } state_t;

  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

  generate
    if (PRESENT != 0) begin : g_present
      state_t      state_reg, state_next;
      logic [31:0] data_reg, data_next;
      logic        maskn_reg, maskn_next;
      logic        req_reg, req_next;
      logic        done_reg, done_next;
      logic        err_reg, err_next;
      logic [15:0] cnt_reg, cnt_next;
      logic [1:0]  ack_sync_reg;
      logic        ack_s;
      logic        accept;
      logic        err_set;
      logic [15:0] cnt_inc;

      // Two-flop synchroniser; nothing else looks at CDC_ACK.
      assign ack_s = ack_sync_reg[1];

      // A high acknowledge while idle is a protocol violation: hold off new
      // words until the destination has released it.
      assign REQ_READY = DPRESETn && (state_reg == st_idle) && !ack_s;
      assign accept    = REQ_VALID && REQ_READY;
      assign cnt_inc   = cnt_reg + 16'd1;

      always_ff @(posedge SWCLKTCK) begin
        if (!DPRESETn) begin
          state_reg    <= st_idle;
          data_reg     <= 32'd0;
          maskn_reg    <= 1'b0;
          req_reg      <= 1'b0;
          done_reg     <= 1'b0;
          err_reg      <= 1'b0;
          cnt_reg      <= 16'd0;
          ack_sync_reg <= 2'b00;
        end else begin
          state_reg    <= state_next;
          data_reg     <= data_next;
          maskn_reg    <= maskn_next;
          req_reg      <= req_next;
          done_reg     <= done_next;
          err_reg      <= err_next;
          cnt_reg      <= cnt_next;
          ack_sync_reg <= {ack_sync_reg[0], CDC_ACK};
        end
      end

      always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        err_set    = 1'b0;
        err_next   = err_reg;

        case (state_reg)
          st_idle: begin
            if (accept) begin
              data_next  = REQ_DATA;
              state_next = st_load;
            end
          end
          st_load: state_next = st_open;
          st_open: begin
            state_next = st_req;
            cnt_next   = 16'd0;
          end
          st_req: begin
            cnt_next = cnt_inc;
            if (ack_s) begin
              state_next = st_release;
              done_next  = 1'b1;
            end else if ((TIMEOUT_L != 16'd0) && (cnt_inc == TIMEOUT_L)) begin
              // Abort: drop the request and wait for the acknowledge to be
              // low in RELEASE, so a late acknowledge is absorbed there.
              state_next = st_release;
              err_set    = 1'b1;
            end
          end
          st_release: begin
            if (!ack_s) state_next = st_idle;
          end
          default: state_next = st_idle;
        endcase

        if (err_set)      err_next = 1'b1;
        else if (ERR_CLR) err_next = 1'b0;

        // Mask and request are registered copies of the next state, so the
        // outputs come straight from flops with no decode glitches.
        maskn_next = (state_next == st_open) || (state_next == st_req);
        req_next   = (state_next == st_req);
      end

      assign CDC_DATA  = data_reg;
      assign CDC_MASKn = maskn_reg;
      assign CDC_REQ   = req_reg;
      assign DONE      = done_reg;
      assign ERR       = err_reg;
    end else begin : g_absent
      assign REQ_READY = 1'b0;
      assign CDC_DATA  = 32'd0;
      assign CDC_MASKn = 1'b0;
      assign CDC_REQ   = 1'b0;
      assign DONE      = 1'b0;
      assign ERR       = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cm0_dap_cdc_xfer_ctrl.sv
// Bench for cm0_dap_cdc_xfer_ctrl: a default instance (no timeout), a
// TIMEOUT=8 instance and a PRESENT=0 instance sharing one clock.
module tb_cm0_dap_cdc_xfer_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        req_valid, cdc_ack, err_clr;
  logic [31:0] req_data;
  logic        req_ready, cdc_maskn, cdc_req, done, err;
  logic [31:0] cdc_data;

  logic        t_valid, t_ack, t_errclr;
  logic [31:0] t_data;
  logic        t_ready, t_maskn, t_req, t_done, t_err;
  logic [31:0] t_cdc_data;

  logic        a_ready, a_maskn, a_req, a_done, a_err;
  logic [31:0] a_cdc_data;

  int passed = 0;
  int total  = 0;

  cm0_dap_cdc_xfer_ctrl dut (
    .SWCLKTCK(clk), .DPRESETn(rstn), .REQ_VALID(req_valid), .REQ_DATA(req_data),
    .REQ_READY(req_ready), .CDC_DATA(cdc_data), .CDC_MASKn(cdc_maskn),
    .CDC_REQ(cdc_req), .CDC_ACK(cdc_ack), .DONE(done), .ERR(err), .ERR_CLR(err_clr)
  );

  cm0_dap_cdc_xfer_ctrl #(.PRESENT(1), .TIMEOUT(8)) dut_to (
    .SWCLKTCK(clk), .DPRESETn(rstn), .REQ_VALID(t_valid), .REQ_DATA(t_data),
    .REQ_READY(t_ready), .CDC_DATA(t_cdc_data), .CDC_MASKn(t_maskn),
    .CDC_REQ(t_req), .CDC_ACK(t_ack), .DONE(t_done), .ERR(t_err), .ERR_CLR(t_errclr)
  );

  cm0_dap_cdc_xfer_ctrl #(.PRESENT(0)) dut_absent (
    .SWCLKTCK(clk), .DPRESETn(rstn), .REQ_VALID(req_valid), .REQ_DATA(req_data),
    .REQ_READY(a_ready), .CDC_DATA(a_cdc_data), .CDC_MASKn(a_maskn),
    .CDC_REQ(a_req), .CDC_ACK(cdc_ack), .DONE(a_done), .ERR(a_err), .ERR_CLR(err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Continuous invariants on the default instance, plus the absent instance.
  bit          mon_en = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic        prev_maskn = 1'b0;
  always @(negedge clk) begin
    chk("absent_outputs_zero", {a_cdc_data[31:27], a_ready, a_maskn, a_req, a_done, a_err} | {26'd0, |a_cdc_data},
        32'd0);
    if (mon_en) begin
      chk("data_stable_while_open",
          32'((cdc_maskn || prev_maskn) && (cdc_data != prev_data)), 32'd0);
      chk("req_implies_maskn", 32'(cdc_req && !cdc_maskn), 32'd0);
    end
    prev_data  = cdc_data;
    prev_maskn = cdc_maskn;
  end

  // One full transfer on the default instance. The acknowledge is raised
  // after CDC_REQ has been seen high for dly+1 samples and dropped once DONE
  // is seen.
  task automatic do_xfer(input logic [31:0] d, input int dly, input int exp_req,
                         input int exp_done, input int exp_rel, input bit detail);
    int  req_cyc = 0, done_cnt = 0, rel = 0, g;
    bit  ack_set = 1'b0, done_seen = 1'b0, finished = 1'b0;
    chk("ready_before_xfer", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_data  = d;
    for (g = 0; g < 200; g++) begin
      step();
      if (g == 0) begin
        req_valid = 1'b0;
        req_data  = $urandom;
      end
      if (detail) begin
        if (g == 0) begin
          chk("load_data", cdc_data, d);
          chk("load_maskn", 32'(cdc_maskn), 32'd0);
          chk("load_req", 32'(cdc_req), 32'd0);
        end
        if (g == 1) begin
          chk("open_maskn", 32'(cdc_maskn), 32'd1);
          chk("open_req", 32'(cdc_req), 32'd0);
        end
        if (g == 2) chk("req_raised", 32'(cdc_req), 32'd1);
      end
      if (cdc_req) begin
        req_cyc++;
        if (!ack_set && req_cyc == dly + 1) begin
          cdc_ack = 1'b1;
          ack_set = 1'b1;
        end
      end
      if (done_seen) rel++;
      if (done) begin
        done_cnt++;
        done_seen = 1'b1;
        cdc_ack   = 1'b0;
      end
      if (done_seen && req_ready) begin
        finished = 1'b1;
        break;
      end
    end
    cdc_ack = 1'b0;
    chk("xfer_finished", 32'(finished), 32'd1);
    chk("xfer_data_held", cdc_data, d);
    chk("xfer_req_cycles", 32'(req_cyc), 32'(exp_req));
    chk("xfer_done_count", 32'(done_cnt), 32'(exp_done));
    chk("xfer_release_cycles", 32'(rel), 32'(exp_rel));
    $display("xfer data=%h ack_dly=%0d req_cyc=%0d done=%0d rel=%0d", d, dly, req_cyc, done_cnt, rel);
  endtask

  typedef struct {
    logic [31:0] data;
    int          ack_dly;
    int          exp_req_cyc;
    int          exp_done;
    int          exp_rel_cyc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{32'hA5A5_5A5A, 1, 4, 1, 3};
    tbl[1] = '{32'h0000_0000, 0, 3, 1, 3};
    tbl[2] = '{32'hFFFF_FFFF, 5, 8, 1, 3};
    tbl[3] = '{32'h1234_5678, 2, 5, 1, 3};
    tbl[4] = '{32'h8000_0001, 20, 23, 1, 3};
    tbl[5] = '{32'h5A5A_A5A5, 3, 6, 1, 3};

    rstn = 1'b0; req_valid = 1'b0; req_data = 32'hFFFF_FFFF; cdc_ack = 1'b0; err_clr = 1'b0;
    t_valid = 1'b0; t_data = 32'd0; t_ack = 1'b0; t_errclr = 1'b0;

    // Reset state, with a request pending to show reset priority.
    req_valid = 1'b1;
    step(); step();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_data", cdc_data, 32'd0);
    chk("rst_maskn", 32'(cdc_maskn), 32'd0);
    chk("rst_req", 32'(cdc_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_to_outputs", {t_cdc_data[31:6], t_ready, t_maskn, t_req, t_done, t_err, |t_cdc_data}, 32'd0);
    req_valid = 1'b0;
    rstn = 1'b1;
    step();
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    mon_en = 1'b1;

    // Table-driven transfers.
    for (int i = 0; i < 6; i++)
      do_xfer(tbl[i].data, tbl[i].ack_dly, tbl[i].exp_req_cyc, tbl[i].exp_done,
              tbl[i].exp_rel_cyc, 1'b1);
    chk("no_err_without_timeout", 32'(err), 32'd0);

    // Stuck acknowledge while idle.
    cdc_ack = 1'b1;
    step();
    chk("stuck_ready_1st", 32'(req_ready), 32'd1);
    step();
    chk("stuck_ready_2nd", 32'(req_ready), 32'd0);
    req_valid = 1'b1;
    req_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stuck_ready_held", 32'(req_ready), 32'd0);
      chk("stuck_data_kept", cdc_data, 32'h5A5A_A5A5);
      chk("stuck_maskn", 32'(cdc_maskn), 32'd0);
    end
    req_valid = 1'b0;
    cdc_ack   = 1'b0;
    step();
    chk("unstick_ready_1st", 32'(req_ready), 32'd0);
    step();
    chk("unstick_ready_2nd", 32'(req_ready), 32'd1);
    $display("stuck ack: valid ignored while ack high");
    do_xfer(32'hCAFE_F00D, 1, 4, 1, 3, 1'b1);

    // Reset in the middle of a transfer.
    req_valid = 1'b1;
    req_data  = 32'h3C3C_C3C3;
    step();
    req_valid = 1'b0;
    step(); step();
    chk("midrst_in_req", 32'(cdc_req), 32'd1);
    mon_en = 1'b0;
    rstn = 1'b0;
    step();
    chk("midrst_data", cdc_data, 32'd0);
    chk("midrst_maskn", 32'(cdc_maskn), 32'd0);
    chk("midrst_req", 32'(cdc_req), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    rstn = 1'b1;
    step();
    mon_en = 1'b1;
    chk("midrst_ready_after", 32'(req_ready), 32'd1);
    $display("reset mid-transfer: outputs cleared");
    do_xfer(32'h0BAD_F00D, 4, 7, 1, 3, 1'b1);

    // Timeout instance: plain timeout, then clear.
    begin
      int tdone = 0;
      t_valid = 1'b1;
      t_data  = 32'hC0DE_0008;
      step();
      t_valid = 1'b0;
      step(); step();
      chk("to_req_k0", 32'(t_req), 32'd1);
      for (int k = 1; k < 8; k++) begin
        step();
        if (t_done) tdone++;
        chk("to_req_held", 32'(t_req), 32'd1);
      end
      chk("to_err_before", 32'(t_err), 32'd0);
      step();
      if (t_done) tdone++;
      chk("to_req_dropped", 32'(t_req), 32'd0);
      chk("to_maskn_dropped", 32'(t_maskn), 32'd0);
      chk("to_err_set", 32'(t_err), 32'd1);
      chk("to_no_done", 32'(tdone), 32'd0);
      step();
      chk("to_ready_after", 32'(t_ready), 32'd1);
      chk("to_err_sticky", 32'(t_err), 32'd1);
      t_errclr = 1'b1;
      step();
      t_errclr = 1'b0;
      chk("to_err_cleared", 32'(t_err), 32'd0);
      $display("timeout: err set after 8 req cycles, cleared");
    end

    // Timeout with a late acknowledge and a coincident clear.
    t_valid = 1'b1;
    t_data  = 32'hC0DE_0009;
    step();
    t_valid = 1'b0;
    step(); step();
    for (int k = 1; k < 7; k++) step();
    t_ack = 1'b1;
    step();
    chk("late_req_k7", 32'(t_req), 32'd1);
    t_errclr = 1'b1;
    step();
    chk("late_req_dropped", 32'(t_req), 32'd0);
    chk("late_set_wins", 32'(t_err), 32'd1);
    chk("late_no_done", 32'(t_done), 32'd0);
    t_errclr = 1'b0;
    step();
    chk("late_absorb_ready", 32'(t_ready), 32'd0);
    chk("late_absorb_done", 32'(t_done), 32'd0);
    t_ack = 1'b0;
    step(); step();
    chk("late_still_release", 32'(t_ready), 32'd0);
    step();
    chk("late_back_idle", 32'(t_ready), 32'd1);
    t_errclr = 1'b1;
    step();
    t_errclr = 1'b0;
    chk("late_err_cleared", 32'(t_err), 32'd0);
    $display("timeout: late ack absorbed in release");

    // Random acknowledge delays.
    for (int i = 0; i < 1000; i++) begin
      int          dly;
      logic [31:0] d;
      d   = $urandom;
      dly = $urandom_range(0, 20);
      do_xfer(d, dly, dly + 3, 1, 3, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
